rle_dec: RTL and testbench

Run-length decoder, the inverse of the Lab 3 run-length encoder. It pops 24-bit encoded words from an input-side FIFO, where bit 23 is the bit value and bits 22:0 are the run length. It expands each word into a serial bit stream, packs that stream LSB-first into bytes, and pushes the bytes to an output-side FIFO. It sits between the encoded-data FIFO and the byte FIFO feeding the host, so that encoder→decoder loopback reproduces the original byte stream.

---
 rtl/rle_dec_if.sv | 22 ++
 rtl/rle_dec.sv | 111 +++++++++++
 tb/tb_rle_dec.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_dec_if.sv
// Handshake bundle between the run-length decoder and its two FIFOs.
// master is the decoder side; slave is the FIFO/host side.
interface rle_dec_if;
  logic        recv_ready;
  logic [23:0] in_data;
  logic        rd_req;
  logic        send_ready;
  logic [7:0]  out_data;
  logic        wr_req;
  logic        end_of_stream;
  logic        done;

  modport master (
    input  recv_ready, in_data, send_ready, end_of_stream,
    output rd_req, out_data, wr_req, done
  );

  modport slave (
    output recv_ready, in_data, send_ready, end_of_stream,
    input  rd_req, out_data, wr_req, done
  );
endinterface

// File: rtl/rle_dec.sv
// Run-length decoder: expands {value, length} words into a bit stream and packs it
// LSB-first into bytes for the output FIFO, flushing any partial byte at end of stream.
module rle_dec (
  input  logic      clk,
  input  logic      rst,
  rle_dec_if.master bus
);

  typedef enum logic [3:0] {
    StIdle,
    StReq,
    StWait,
    StLoad,
    StExpand,
    StWrWait,
    StWrPulse,
    StFlush,
    StFlWait,
    StFlPulse,
    StDone
  } state_e;

  state_e      state;
  logic        val;
  logic [22:0] remain;
  logic [7:0]  byte_buf;
  logic [2:0]  bit_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= StIdle;
      val          <= 1'b0;
      remain       <= 23'd0;
      byte_buf     <= 8'h00;
      bit_idx      <= 3'd0;
      bus.rd_req   <= 1'b0;
      bus.wr_req   <= 1'b0;
      bus.out_data <= 8'h00;
      bus.done     <= 1'b0;
    end else begin
      // Request strobes are single-cycle unless re-armed below.
      bus.rd_req <= 1'b0;
      bus.wr_req <= 1'b0;
      unique case (state)
        StIdle: begin
          byte_buf <= 8'h00;
          bit_idx  <= 3'd0;
          state    <= StReq;
        end
        StReq: begin
          if (bus.recv_ready) begin
            bus.rd_req <= 1'b1;
            state      <= StWait;
          end else if (bus.end_of_stream) begin
            if (bit_idx != 3'd0) begin
              state <= StFlush;
            end else begin
              bus.done <= 1'b1;
              state    <= StDone;
            end
          end
        end
        StWait: state <= StLoad;
        StLoad: begin
          val    <= bus.in_data[23];
          remain <= bus.in_data[22:0];
          state  <= (bus.in_data[22:0] == 23'd0) ? StReq : StExpand;
        end
        StExpand: begin
          remain  <= remain - 23'd1;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            bus.out_data <= {val, byte_buf[6:0]};
            byte_buf     <= 8'h00;
            state        <= StWrWait;
          end else begin
            byte_buf[bit_idx] <= val;
            if (remain == 23'd1) state <= StReq;
          end
        end
        StWrWait: begin
          if (bus.send_ready) begin
            bus.wr_req <= 1'b1;
            state      <= StWrPulse;
          end
        end
        StWrPulse: state <= (remain != 23'd0) ? StExpand : StReq;
        StFlush: begin
          // Unfilled upper bits are already zero since byte_buf clears per byte.
          bus.out_data <= byte_buf;
          byte_buf     <= 8'h00;
          bit_idx      <= 3'd0;
          state        <= StFlWait;
        end
        StFlWait: begin
          if (bus.send_ready) begin
            bus.wr_req <= 1'b1;
            state      <= StFlPulse;
          end
        end
        StFlPulse: begin
          bus.done <= 1'b1;
          state    <= StDone;
        end
        StDone: state <= StDone;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_dec.sv
// Scoreboard bench for rle_dec: FIFO models on both sides, expected bytes derived
// from the encoded words by a bit-level packing model.
module tb_rle_dec;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rle_dec_if bus ();
  rle_dec dut (.clk(clk), .rst(rst), .bus(bus));

  logic [23:0] in_q[$];
  logic [23:0] stim[$];
  logic [7:0]  act_q[$];
  logic [7:0]  exp_q[$];
  int rd_cnt = 0;
  int wr_cnt = 0;
  int checks = 0;
  int errors = 0;

  // Input FIFO presents the popped word from the cycle after rd_req; output FIFO logs writes.
  always @(negedge clk) begin
    if (bus.rd_req === 1'b1) begin
      rd_cnt++;
      if (in_q.size() != 0) bus.in_data = in_q.pop_front();
    end
    if (bus.wr_req === 1'b1) begin
      wr_cnt++;
      act_q.push_back(bus.out_data);
    end
    bus.recv_ready = (in_q.size() != 0);
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.send_ready = 1'b1;
    bus.end_of_stream = 1'b0;
    in_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Queue the words and push the bytes they should decode to onto the scoreboard.
  task automatic load_stim(input bit flush);
    logic [7:0] acc;
    int idx;
    acc = 8'h00;
    idx = 0;
    foreach (stim[i]) begin
      for (int k = 0; k < int'(stim[i][22:0]); k++) begin
        acc[idx] = stim[i][23];
        idx++;
        if (idx == 8) begin
          exp_q.push_back(acc);
          acc = 8'h00;
          idx = 0;
        end
      end
      in_q.push_back(stim[i]);
    end
    if (flush && idx != 0) exp_q.push_back(acc);
    stim.delete();
  endtask

  task automatic wait_bytes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (act_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int rd0;
    do_reset();
    checks++; if (bus.rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req got %b want 0", bus.rd_req); end
    checks++; if (bus.wr_req !== 1'b0) begin errors++; $display("FAIL reset_wr_req got %b want 0", bus.wr_req); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
    rd0 = rd_cnt;
    repeat (6) @(negedge clk);
    checks++; if (rd_cnt != rd0) begin errors++; $display("FAIL reset_idle_rd got %0d want 0", rd_cnt - rd0); end
  endtask

  task automatic test_single_byte();
    int base, rd0, wr0, n;
    bit ok;
    logic [7:0] a, e;
    do_reset();
    base = act_q.size(); rd0 = rd_cnt; wr0 = wr_cnt;
    stim.push_back({1'b1, 23'd8});
    load_stim(1'b0);
    n = exp_q.size();
    wait_bytes(base + n, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout got %0d want %0d", act_q.size() - base, n); end
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      a = (base + i < act_q.size()) ? act_q[base + i] : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL single_byte%0d got %h want %h", i, a, e); end
    end
    repeat (10) @(negedge clk);
    checks++; if (rd_cnt - rd0 != 1) begin errors++; $display("FAIL single_rd got %0d want 1", rd_cnt - rd0); end
    checks++; if (wr_cnt - wr0 != 1) begin errors++; $display("FAIL single_wr got %0d want 1", wr_cnt - wr0); end
  endtask

  task automatic test_multi_word();
    int base, rd0, wr0, n;
    bit ok;
    logic [7:0] a, e;
    do_reset();
    base = act_q.size(); rd0 = rd_cnt; wr0 = wr_cnt;
    stim.push_back({1'b1, 23'd3});
    stim.push_back({1'b0, 23'd2});
    stim.push_back({1'b1, 23'd3});
    load_stim(1'b0);
    n = exp_q.size();
    wait_bytes(base + n, 150, ok);
    checks++; if (!ok) begin errors++; $display("FAIL multi_timeout got %0d want %0d", act_q.size() - base, n); end
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      a = (base + i < act_q.size()) ? act_q[base + i] : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL multi_byte%0d got %h want %h", i, a, e); end
    end
    repeat (10) @(negedge clk);
    checks++; if (rd_cnt - rd0 != 3) begin errors++; $display("FAIL multi_rd got %0d want 3", rd_cnt - rd0); end
    checks++; if (wr_cnt - wr0 != 1) begin errors++; $display("FAIL multi_wr got %0d want 1", wr_cnt - wr0); end
  endtask

  task automatic test_flush();
    int base, rd0, n;
    bit ok, held;
    logic [7:0] a, e;
    do_reset();
    base = act_q.size(); rd0 = rd_cnt;
    stim.push_back({1'b0, 23'd5});
    stim.push_back({1'b1, 23'd1});
    load_stim(1'b1);
    bus.end_of_stream = 1'b1;
    n = exp_q.size();
    wait_bytes(base + n, 150, ok);
    checks++; if (!ok) begin errors++; $display("FAIL flush_timeout got %0d want %0d", act_q.size() - base, n); end
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      a = (base + i < act_q.size()) ? act_q[base + i] : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL flush_byte%0d got %h want %h", i, a, e); end
    end
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk);
      ok = (bus.done === 1'b1);
    end
    checks++; if (!ok) begin errors++; $display("FAIL flush_done got %b want 1", bus.done); end
    held = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.done !== 1'b1) held = 1'b0;
    end
    checks++; if (!held) begin errors++; $display("FAIL flush_done_sticky got %b want 1", held); end
    checks++; if (rd_cnt - rd0 != 2) begin errors++; $display("FAIL flush_rd got %0d want 2", rd_cnt - rd0); end
  endtask

  task automatic test_backpressure();
    int base, wr0, n;
    bit ok;
    logic [7:0] a, e;
    do_reset();
    bus.send_ready = 1'b0;
    base = act_q.size(); wr0 = wr_cnt;
    stim.push_back({1'b1, 23'd16});
    load_stim(1'b0);
    n = exp_q.size();
    repeat (24) @(negedge clk);
    checks++; if (wr_cnt != wr0) begin errors++; $display("FAIL bp_withheld got %0d want 0", wr_cnt - wr0); end
    bus.send_ready = 1'b1;
    wait_bytes(base + n, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got %0d want %0d", act_q.size() - base, n); end
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      a = (base + i < act_q.size()) ? act_q[base + i] : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, a, e); end
    end
    repeat (15) @(negedge clk);
    checks++; if (wr_cnt - wr0 != 2) begin errors++; $display("FAIL bp_wr got %0d want 2", wr_cnt - wr0); end
  endtask

  task automatic test_zero_len();
    int base, rd0, wr0, n;
    bit ok;
    logic [7:0] a, e;
    do_reset();
    base = act_q.size(); rd0 = rd_cnt; wr0 = wr_cnt;
    stim.push_back({1'b0, 23'd4});
    stim.push_back({1'b1, 23'd0});
    stim.push_back({1'b1, 23'd4});
    load_stim(1'b0);
    n = exp_q.size();
    wait_bytes(base + n, 150, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_timeout got %0d want %0d", act_q.size() - base, n); end
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      a = (base + i < act_q.size()) ? act_q[base + i] : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL zero_byte%0d got %h want %h", i, a, e); end
    end
    repeat (10) @(negedge clk);
    checks++; if (rd_cnt - rd0 != 3) begin errors++; $display("FAIL zero_rd got %0d want 3", rd_cnt - rd0); end
    checks++; if (wr_cnt - wr0 != 1) begin errors++; $display("FAIL zero_wr got %0d want 1", wr_cnt - wr0); end
  endtask

  task automatic test_reset_mid_run();
    int base, rd0, wr0, n;
    bit ok;
    logic [7:0] a, e;
    do_reset();
    base = act_q.size(); wr0 = wr_cnt;
    stim.push_back({1'b1, 23'd1000});
    load_stim(1'b0);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = (wr_cnt - wr0 >= 3);
    end
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout got %0d want 3", wr_cnt - wr0); end
    for (int i = 0; i < 3; i++) begin
      a = (base + i < act_q.size()) ? act_q[base + i] : 8'hxx;
      checks++; if (a !== 8'hFF) begin errors++; $display("FAIL mid_byte%0d got %h want ff", i, a); end
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.rd_req !== 1'b0) begin errors++; $display("FAIL mid_rst_rd got %b want 0", bus.rd_req); end
    checks++; if (bus.wr_req !== 1'b0) begin errors++; $display("FAIL mid_rst_wr got %b want 0", bus.wr_req); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b want 0", bus.done); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL mid_rst_out got %h want 00", bus.out_data); end
    do_reset();
    // A fresh 8-bit run must land as one whole byte, proving bit_idx restarted at 0.
    base = act_q.size(); rd0 = rd_cnt;
    stim.push_back({1'b1, 23'd8});
    load_stim(1'b0);
    n = exp_q.size();
    wait_bytes(base + n, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL post_rst_timeout got %0d want %0d", act_q.size() - base, n); end
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      a = (base + i < act_q.size()) ? act_q[base + i] : 8'hxx;
      checks++; if (a !== e) begin errors++; $display("FAIL post_rst_byte%0d got %h want %h", i, a, e); end
    end
    checks++; if (rd_cnt - rd0 != 1) begin errors++; $display("FAIL post_rst_rd got %0d want 1", rd_cnt - rd0); end
  endtask

  initial begin
    rst = 1'b1;
    bus.send_ready = 1'b1;
    bus.end_of_stream = 1'b0;
    test_reset();
    test_single_byte();
    test_multi_word();
    test_flush();
    test_backpressure();
    test_zero_len();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
